// File: rtl/tomasulo_rs.sv
// ---------------------------------------------------------------------------
// tomasulo_pkg / tomasulo_rs
//
// Reservation station for the Tomasulo pipeline. It accepts dispatched
// instructions whose operands are either present or pending on a producer
// tag. It snoops the registered CDB to capture pending operands, and it issues
// at most one fully-ready instruction per cycle to its execution unit.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   dis_*         dispatch request (vld, op, tag, per-operand rdy/tag/value)
//   dis_rdy       a free entry exists (current state only)
//   cdb_r         registered CDB broadcast {vld, tag, wdata}
//   iss_vld, iss  registered issue to the execution unit {op, tag, a, b}
//
// Handshake: a dispatch transfers on a clock edge where dis_vld && dis_rdy.
// dis_vld with dis_rdy low is dropped. The issue side has no ready signal;
// every cycle with iss_vld=1 is consumed by the execution unit.
// ---------------------------------------------------------------------------
package tomasulo_pkg;
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4
   } op_t;

   typedef logic [3:0]  tag_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      logic  vld;
      tag_t  tag;
      word_t wdata;
   } cdb_t;

   typedef struct packed {
      op_t   op;
      tag_t  tag;
      word_t a;
      word_t b;
   } issue_t;
endpackage

module tomasulo_rs
   import tomasulo_pkg::*;
#(
   parameter int N = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   dis_vld,
   input  op_t    dis_op,
   input  tag_t   dis_tag,
   input  logic   dis_a_rdy,
   input  logic   dis_b_rdy,
   input  tag_t   dis_a_tag,
   input  tag_t   dis_b_tag,
   input  word_t  dis_a,
   input  word_t  dis_b,
   output logic   dis_rdy,
   input  cdb_t   cdb_r,
   output logic   iss_vld,
   output issue_t iss
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef struct packed {
      logic  vld;
      op_t   op;
      tag_t  tag;
      logic  a_rdy;
      tag_t  a_tag;
      word_t a;
      logic  b_rdy;
      tag_t  b_tag;
      word_t b;
   } entry_t;

   entry_t         ent_q [N];
   entry_t         ent_d [N];
   entry_t         new_ent;
   logic           any_free;
   logic [IW-1:0]  free_idx;
   logic           any_sel;
   logic [IW-1:0]  sel_idx;

   // Lowest-index free entry and lowest-index ready entry. Iterating from the
   // top down lets the lowest index overwrite any higher match. Select reads
   // registered rdy bits only, so a wakeup is never selected in its own cycle.
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      any_sel  = 1'b0;
      sel_idx  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!ent_q[i].vld) begin
            any_free = 1'b1;
            free_idx = IW'(i);
         end
         if (ent_q[i].vld && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
            any_sel = 1'b1;
            sel_idx = IW'(i);
         end
      end
   end

   assign dis_rdy = any_free;

   // Incoming entry, with a same-cycle CDB match folded in so the operand
   // does not miss a broadcast that is already on the bus.
   always_comb begin
      new_ent       = '0;
      new_ent.vld   = 1'b1;
      new_ent.op    = dis_op;
      new_ent.tag   = dis_tag;
      new_ent.a_rdy = dis_a_rdy;
      new_ent.a_tag = dis_a_tag;
      new_ent.a     = dis_a;
      new_ent.b_rdy = dis_b_rdy;
      new_ent.b_tag = dis_b_tag;
      new_ent.b     = dis_b;
      if (cdb_r.vld && !dis_a_rdy && (dis_a_tag == cdb_r.tag)) begin
         new_ent.a_rdy = 1'b1;
         new_ent.a     = cdb_r.wdata;
      end
      if (cdb_r.vld && !dis_b_rdy && (dis_b_tag == cdb_r.tag)) begin
         new_ent.b_rdy = 1'b1;
         new_ent.b     = cdb_r.wdata;
      end
   end

   // Next state: wakeup, free the selected entry, then write the dispatch.
   // The free slot is never the selected slot (selected entries are valid),
   // and a selected entry is fully ready so wakeup cannot touch it.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].vld && cdb_r.vld) begin
            if (!ent_q[i].a_rdy && (ent_q[i].a_tag == cdb_r.tag)) begin
               ent_d[i].a_rdy = 1'b1;
               ent_d[i].a     = cdb_r.wdata;
            end
            if (!ent_q[i].b_rdy && (ent_q[i].b_tag == cdb_r.tag)) begin
               ent_d[i].b_rdy = 1'b1;
               ent_d[i].b     = cdb_r.wdata;
            end
         end
      end
      if (any_sel) begin
         ent_d[sel_idx].vld = 1'b0;
      end
      if (dis_vld && any_free) begin
         ent_d[free_idx] = new_ent;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            ent_q[i] <= '0;
         end
         iss_vld <= 1'b0;
         iss     <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            ent_q[i] <= ent_d[i];
         end
         iss_vld <= any_sel;
         if (any_sel) begin
            iss <= '{op:  ent_q[sel_idx].op,
                     tag: ent_q[sel_idx].tag,
                     a:   ent_q[sel_idx].a,
                     b:   ent_q[sel_idx].b};
         end
      end
   end

endmodule
